// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: instruction memory port, redirect input, decode handshake and perf counters.
interface ifetch_unit_if;
  import ifetch_pkg::*;

  logic [WORD_W-1:0] imem_address;
  logic [WORD_W-1:0] imem_instruction;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instruction;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_pc_plus4;
  logic              misaligned;
  logic [WORD_W-1:0] fetch_count;
  logic [WORD_W-1:0] flush_count;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output out_pc_plus4,
    output misaligned,
    output fetch_count,
    output flush_count
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  out_pc_plus4,
    input  misaligned,
    input  fetch_count,
    input  flush_count
  );

endinterface

// File: rtl/fetch_queue.sv
// Small flop-based FIFO of fetch entries; flush overrides push and pop.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC sequencing, redirect flush, prefetch queue to decode.
// Optional saturating perf counters are built when IFETCH_PERF_COUNTERS_EN is defined.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                QUEUE_DEPTH = 2
) (
  input logic         clock,
  input logic         reset_n,
  ifetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [WORD_W-1:0] fetch_pc_reg;
  logic [WORD_W-1:0] fetch_pc_next;
  logic              misaligned_reg;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              out_valid;
  logic              pop;
  logic              can_push;
  logic              push;

  assign out_valid  = (count != '0);
  assign pop        = out_valid & bus.out_ready;
  assign can_push   = (count < CNT_W'(QUEUE_DEPTH)) | pop;
  // A redirect discards whatever would have been captured this cycle.
  assign push       = can_push & ~bus.redirect_valid;
  assign push_entry = '{pc: fetch_pc_reg, instruction: bus.imem_instruction};

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (bus.redirect_valid)
      fetch_pc_next = align_word(bus.redirect_target);
    else if (can_push)
      fetch_pc_next = fetch_pc_reg + WORD_W'(INSTR_BYTES);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg   <= RESET_PC;
      misaligned_reg <= 1'b0;
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      misaligned_reg <= bus.redirect_valid & (|bus.redirect_target[1:0]);
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop & ~bus.redirect_valid),
    .flush      (bus.redirect_valid),
    .head       (head),
    .count      (count)
  );

  assign bus.imem_address    = fetch_pc_reg;
  assign bus.out_valid       = out_valid;
  assign bus.out_instruction = head.instruction;
  assign bus.out_pc          = head.pc;
  // Forced to zero while empty so the reset value is zero rather than RESET_PC-independent +4.
  assign bus.out_pc_plus4    = out_valid ? head.pc + WORD_W'(INSTR_BYTES) : '0;
  assign bus.misaligned      = misaligned_reg;

`ifdef IFETCH_PERF_COUNTERS_EN
  logic [WORD_W-1:0] fetch_count_reg;
  logic [WORD_W-1:0] flush_count_reg;
  logic [WORD_W:0]   flush_sum;

  assign flush_sum = {1'b0, flush_count_reg} + (WORD_W + 1)'(count);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (push && (fetch_count_reg != '1))
        fetch_count_reg <= fetch_count_reg + WORD_W'(1);
      if (bus.redirect_valid)
        flush_count_reg <= flush_sum[WORD_W] ? '1 : flush_sum[WORD_W-1:0];
    end
  end

  assign bus.fetch_count = fetch_count_reg;
  assign bus.flush_count = flush_count_reg;
`else
  assign bus.fetch_count = '0;
  assign bus.flush_count = '0;
`endif

endmodule
